// File: rtl/param_sync_fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the param_sync_fifo slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default word and pointer widths
//   count_width()                           : occupancy counter width, which must
//                                             hold 0..DEPTH inclusive
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // One extra bit so that count can reach DEPTH = 2**addr_width.
  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: handshake and status bundle of the synchronous FIFO.
//   master : producer/consumer side (drives wr_en, data_in, rd_en)
//   slave  : FIFO side (drives data_out, rd_valid, status flags, count, error pulses)
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic                                wr_en;
  logic [DATA_WIDTH-1:0]               data_in;
  logic                                rd_en;
  logic [DATA_WIDTH-1:0]               data_out;
  logic                                rd_valid;
  logic                                full;
  logic                                empty;
  logic                                almost_full;
  logic                                almost_empty;
  logic [count_width(ADDR_WIDTH)-1:0]  count;
  logic                                overflow;
  logic                                underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/param_sync_fifo_ram.sv
// fifo_ram: simple dual-port storage, one write port and one registered read port.
//   clk, rst_n      : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  : write port
//   re/raddr        : read request; rdata updates on the next edge when re=1
//   rdata           : registered read data, holds when re=0
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset; stale words are unreachable once
  // pointers and count are cleared.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count, threshold flags and
// overflow/underflow pulses. Pointers, count and flags live here; storage is fifo_ram.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : slave side of param_sync_fifo_if (handshake, data, status)
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  param_sync_fifo_if.slave   bus
);

  localparam int              DEPTH = 1 << ADDR_WIDTH;
  localparam int              CW    = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_TH_C = CW'(ALMOST_FULL_TH);
  localparam logic [CW-1:0]   AE_TH_C = CW'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] data_out;

  // Flags come from the registered count only, so they never combinationally
  // depend on this cycle's requests.
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = bus.wr_en && full;
    underflow_d = bus.rd_en && empty;
    // Pointers are exactly ADDR_WIDTH bits, so the increment wraps modulo DEPTH.
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Write gated by reset_n so reset fully dominates a concurrent request.
  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (wr_acc && reset_n),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (data_out)
  );

  assign bus.data_out     = data_out;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_TH_C);
  assign bus.almost_empty = (count_q <= AE_TH_C);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule
